dmem_responder: RTL and testbench

- Responder end of the core's data-memory handshake. It accepts one load/store request at a time, performs it on an internal word-organised RAM, and returns a response after a fixed latency.
- It holds the response until the core acknowledges it.
- Sits between the core's mem_in_s/data address outputs and its mem_out_s input; one instance per core.

---
 rtl/dmem_responder_pkg.sv | 50 +++++
 rtl/dmem_ram.sv | 36 +++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_responder_pkg;

    // Core -> responder request/handshake bundle.
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    // Responder -> core response/handshake bundle.
    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Pick the response word: full word, or the addressed byte zero-extended (lane 0 = bits 7:0).
    function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic        byte_sel);
        logic [31:0] res;
        if (byte_sel) begin
            res = {24'b0, word[{lane, 3'b000} +: 8]};
        end else begin
            res = word;
        end
        return res;
    endfunction

    // Byte-lane write enables for a store.
    function automatic logic [3:0] lane_mask(input logic [1:0] lane, input logic byte_sel);
        logic [3:0] m;
        if (byte_sel) begin
            m = 4'b0001 << lane;
        end else begin
            m = 4'b1111;
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, 32-bit words with byte-lane write enables.
// Read data appears the cycle after the address and holds until the next read.
module dmem_ram #(
    parameter int unsigned addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    i_en,
    input  logic                    i_we,
    input  logic [3:0]              i_be,
    input  logic [addr_width_p-1:0] i_addr,
    input  logic [31:0]             i_wdata,
    output logic [31:0]             o_rdata
);
    localparam int unsigned Depth = 1 << addr_width_p;

    logic [31:0] r_mem [Depth];
    logic [31:0] r_rdata;

    // Byte-lane write or registered read on an enabled cycle.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int l = 0; l < 4; l++) begin
                    if (i_be[l]) begin
                        r_mem[i_addr][l*8 +: 8] <= i_wdata[l*8 +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core's data-memory handshake: one request in flight, fixed latency,
// response held until the core acknowledges it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned addr_width_p = 10,
    parameter int unsigned latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     from_core_i,
    input  logic [31:0] addr_i,
    output mem_out_s    to_core_o,
    output logic        error_o,
    output logic        busy_o
);
    localparam int unsigned  CntW    = (latency_p > 1) ? $clog2(latency_p + 1) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(latency_p);

    dmem_state_e           r_state;
    logic [CntW-1:0]       r_cnt;
    logic                  r_valid;
    logic                  r_error;
    logic [1:0]            r_lane;
    logic                  r_byte;
    logic                  r_load;

    logic                    w_accept;
    logic [addr_width_p-1:0] w_index;
    logic                    w_high_err;
    logic                    w_align_err;
    logic [3:0]              w_be;
    logic [31:0]             w_wdata;
    logic [31:0]             w_ram_rdata;

    // Accept decode: only in IDLE, and never while reset is held low.
    always_comb begin
        w_accept    = (r_state == IDLE) && from_core_i.valid && reset;
        w_index     = addr_i[addr_width_p+1:2];
        // Out-of-range addresses simply wrap; misaligned words are aligned down by w_index.
        w_high_err  = |addr_i[31:addr_width_p+2];
        w_align_err = !from_core_i.byte_not_word && (|addr_i[1:0]);
        w_be        = lane_mask(addr_i[1:0], from_core_i.byte_not_word);
        w_wdata     = from_core_i.byte_not_word ? {4{from_core_i.write_data[7:0]}}
                                                : from_core_i.write_data;
    end

    dmem_ram #(
        .addr_width_p(addr_width_p)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_accept),
        .i_we    (from_core_i.wen),
        .i_be    (w_be),
        .i_addr  (w_index),
        .i_wdata (w_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Control FSM: accept, latency countdown, hold response until yumi; sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_error <= 1'b0;
            r_lane  <= 2'b00;
            r_byte  <= 1'b0;
            r_load  <= 1'b0;
        end else begin
            if (w_accept && (w_high_err || w_align_err)) begin
                r_error <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_lane <= addr_i[1:0];
                        r_byte <= from_core_i.byte_not_word;
                        r_load <= !from_core_i.wen;
                        if (latency_p > 0) begin
                            r_state <= WAIT;
                            r_cnt   <= CntInit;
                        end else begin
                            r_state <= RESP;
                            r_valid <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CntW'(1);
                    if (r_cnt == CntW'(1)) begin
                        r_state <= RESP;
                        r_valid <= 1'b1;
                    end
                end
                RESP: begin
                    // Requests arriving alongside yumi are left for the next IDLE cycle.
                    if (from_core_i.yumi) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Response drive: RAM read register only changes on accept, so data is stable in RESP.
    always_comb begin
        to_core_o           = '0;
        to_core_o.valid     = r_valid;
        to_core_o.yumi      = w_accept;
        to_core_o.read_data = (r_valid && r_load) ? lane_extend(w_ram_rdata, r_lane, r_byte)
                                                  : 32'h0;
        error_o             = r_error;
        busy_o              = (r_state != IDLE);
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// against a byte-addressed memory model.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned Aw      = 10;
    localparam int unsigned Lat     = 2;
    localparam int unsigned MemSize = 4 << Aw;

    logic        clk = 1'b0;
    logic        rst_n;
    mem_in_s     a_in, b_in;
    mem_out_s    a_out, b_out;
    logic [31:0] a_addr, b_addr;
    logic        a_err, b_err, a_busy, b_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_b [MemSize];
    logic       exp_err;

    always #5 clk = ~clk;

    dmem_responder #(.addr_width_p(Aw), .latency_p(Lat)) dut (
        .clk(clk), .reset(rst_n), .from_core_i(a_in), .addr_i(a_addr),
        .to_core_o(a_out), .error_o(a_err), .busy_o(a_busy)
    );

    dmem_responder #(.addr_width_p(Aw), .latency_p(0)) dut0 (
        .clk(clk), .reset(rst_n), .from_core_i(b_in), .addr_i(b_addr),
        .to_core_o(b_out), .error_o(b_err), .busy_o(b_busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-addressed memory: wraps modulo memory size, words aligned down.
    task automatic model(input logic [31:0] addr, input logic wen, input logic bnw,
                         input logic [31:0] wdata, output logic [31:0] exp);
        int unsigned b;
        int unsigned base;
        b = addr % MemSize;
        if (addr >= MemSize || (!bnw && (addr % 4) != 0)) exp_err = 1'b1;
        exp = 32'h0;
        if (bnw) begin
            if (wen) mem_b[b] = wdata[7:0];
            else     exp = {24'h0, mem_b[b]};
        end else begin
            base = b - (b % 4);
            for (int k = 0; k < 4; k++) begin
                if (wen) mem_b[base + k] = wdata[k*8 +: 8];
                else     exp[k*8 +: 8] = mem_b[base + k];
            end
        end
    endtask

    // Full handshake on the latency-2 instance with all timing/data checks.
    task automatic xact(input logic [31:0] addr, input logic wen, input logic bnw,
                        input logic [31:0] wdata, input int hold, input bit overlap);
        logic [31:0] exp;
        int n;
        model(addr, wen, bnw, wdata, exp);
        @(negedge clk);
        a_addr             = addr;
        a_in.wen           = wen;
        a_in.byte_not_word = bnw;
        a_in.write_data    = wdata;
        a_in.valid         = 1'b1;
        #1 chk("accept_yumi", {31'h0, a_out.yumi}, 32'h1);
        @(negedge clk);
        a_in.valid = 1'b0;
        n = 1;
        while (!a_out.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, Lat + 1);
        chk("read_data", a_out.read_data, exp);
        chk("error", {31'h0, a_err}, {31'h0, exp_err});
        chk("busy_resp", {31'h0, a_busy}, 32'h1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {31'h0, a_out.valid}, 32'h1);
            chk("hold_data", a_out.read_data, exp);
        end
        @(negedge clk);
        a_in.yumi = 1'b1;
        if (overlap) begin
            a_in.wen   = 1'b0;
            a_in.valid = 1'b1;
            #1 chk("resp_no_accept", {31'h0, a_out.yumi}, 32'h0);
        end
        @(negedge clk);
        a_in.yumi = 1'b0;
        chk("valid_drop", {31'h0, a_out.valid}, 32'h0);
        chk("busy_idle", {31'h0, a_busy}, 32'h0);
        if (overlap) begin
            #1 chk("idle_accept", {31'h0, a_out.yumi}, 32'h1);
            a_in.valid = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] exp_b [5];
        logic [31:0] req_a [5];
        logic [31:0] req_d [5];
        logic        req_w [5];
        logic [31:0] junk;
        int idx;

        exp_err = 1'b0;
        a_in = '0; b_in = '0; a_addr = '0; b_addr = '0;
        rst_n = 1'b0;
        a_in.valid = 1'b1;
        #12;
        chk("rst_valid", {31'h0, a_out.valid}, 32'h0);
        chk("rst_rdata", a_out.read_data, 32'h0);
        chk("rst_error", {31'h0, a_err}, 32'h0);
        chk("rst_busy", {31'h0, a_busy}, 32'h0);
        chk("rst_yumi", {31'h0, a_out.yumi}, 32'h0);
        @(negedge clk);
        a_in.valid = 1'b0;
        rst_n = 1'b1;

        // Word store/load.
        xact(32'h10, 1'b1, 1'b0, 32'hDEADBEEF, 0, 1'b0);
        xact(32'h10, 1'b0, 1'b0, 32'h0, 0, 1'b0);
        chk("deadbeef", a_out.read_data, 32'h0); // dropped after yumi
        // Byte store into an existing word.
        xact(32'h10, 1'b1, 1'b0, 32'h11223344, 0, 1'b0);
        xact(32'h13, 1'b1, 1'b1, 32'hFFFFFFA5, 0, 1'b0);
        model(32'h10, 1'b0, 1'b0, 32'h0, junk);
        chk("byte_merge_model", junk, 32'hA5223344);
        xact(32'h10, 1'b0, 1'b0, 32'h0, 0, 1'b0);
        xact(32'h12, 1'b0, 1'b1, 32'h0, 0, 1'b0);
        // Held response for 5 cycles, with a request colliding with yumi.
        xact(32'h10, 1'b0, 1'b0, 32'h0, 5, 1'b1);

        // Reset during WAIT after a store.
        model(32'h20, 1'b1, 1'b0, 32'h5A5A1234, junk);
        @(negedge clk);
        a_addr = 32'h20; a_in.wen = 1'b1; a_in.byte_not_word = 1'b0;
        a_in.write_data = 32'h5A5A1234; a_in.valid = 1'b1;
        #1 chk("rst_accept", {31'h0, a_out.yumi}, 32'h1);
        @(negedge clk);
        chk("wait_busy", {31'h0, a_busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'h0, a_out.valid}, 32'h0);
        chk("midrst_busy", {31'h0, a_busy}, 32'h0);
        chk("midrst_yumi", {31'h0, a_out.yumi}, 32'h0);
        @(negedge clk);
        a_in.valid = 1'b0;
        rst_n = 1'b1;
        exp_err = 1'b0;
        xact(32'h20, 1'b0, 1'b0, 32'h0, 0, 1'b0);

        // Randomized traffic over words 0..15.
        for (int i = 0; i < 16; i++) xact(i * 4, 1'b1, 1'b0, $urandom, 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] addr;
            addr = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) addr = addr | ($urandom_range(1, 255) << 12);
            xact(addr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 $urandom_range(0, 3), 1'b0);
        end

        // Wrapped and misaligned word load sets the sticky error.
        rst_n = 1'b0;
        #1 chk("err_cleared", {31'h0, a_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_err = 1'b0;
        xact(32'h4002, 1'b0, 1'b0, 32'h0, 0, 1'b0);
        chk("err_set", {31'h0, a_err}, 32'h1);
        xact(32'h4, 1'b0, 1'b0, 32'h0, 0, 1'b0);
        chk("err_sticky", {31'h0, a_err}, 32'h1);

        // Zero-latency instance, core holding valid and yumi high.
        req_a = '{32'h0, 32'h8, 32'h0, 32'h8, 32'h0};
        req_w = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        req_d = '{32'hCAFEF00D, 32'h01234567, 32'h0, 32'h0, 32'h0};
        exp_b = '{32'h0, 32'h0, 32'hCAFEF00D, 32'h01234567, 32'hCAFEF00D};
        idx = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b_addr = req_a[idx % 5]; b_in.wen = req_w[idx % 5];
            b_in.write_data = req_d[idx % 5]; b_in.byte_not_word = 1'b0;
            b_in.valid = 1'b1; b_in.yumi = 1'b1;
            #1;
            chk("l0_yumi", {31'h0, b_out.yumi}, {31'h0, (i % 2) == 0});
            chk("l0_valid", {31'h0, b_out.valid}, {31'h0, (i % 2) == 1});
            if (i % 2 == 1) chk("l0_data", b_out.read_data, exp_b[i / 2]);
            if (b_out.yumi) idx++;
        end
        @(negedge clk);
        b_in.valid = 1'b0; b_in.yumi = 1'b0;
        chk("l0_error", {31'h0, b_err}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
